decoder38_pulse: RTL and testbench

DECODER38_PULSE -- requirements
Module: decoder38_pulse

---
 rtl/decoder38_pulse.sv | 135 +++++++++++++
 tb/tb_decoder38_pulse.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/decoder38_pulse.sv
// decoder38_pulse
//   Queues 3-bit line codes in a small FIFO and replays each one as a
//   one-hot pulse on out. Each pulse is held for HOLD cycles and followed
//   by GAP forced-zero cycles.
//
// Parameters
//   DEPTH : code-queue entries (power of two, 2..16)
//   HOLD  : cycles a decoded line stays asserted (>=1)
//   GAP   : forced-zero cycles after each pulse (>=0)
//
// Ports
//   clk       : clock, rising-edge
//   rst       : synchronous active-high reset
//   en        : decode enable; low blocks pops and aborts an active pulse
//   in_valid  : in_code presented
//   in_code   : line index 0..7
//   in_ready  : queue not full (combinational from registered fill)
//   out       : registered one-hot decoded line
//   out_valid : registered, high while out is non-zero
//   fill      : registered queue occupancy
//   overflow  : sticky, set on in_valid while not ready
module decoder38_pulse #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned HOLD  = 2,
   parameter int unsigned GAP   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       in_valid,
   input  logic [2:0]                 in_code,
   output logic                       in_ready,
   output logic [7:0]                 out,
   output logic                       out_valid,
   output logic [$clog2(DEPTH):0]     fill,
   output logic                       overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned FW = AW + 1;

   typedef enum logic [1:0] {IDLE, DRIVE, GAP_ST} state_t;

   state_t          state, state_n;
   logic [15:0]     cnt, cnt_n;
   logic [7:0]      out_n;
   logic            out_valid_n;
   logic            push, pop;
   logic [2:0]      mem [DEPTH];
   logic [AW-1:0]   wptr, rptr;

   // No bypass: a full queue refuses input even when popping this cycle.
   assign in_ready = (fill != FW'(DEPTH));
   assign push     = in_valid & in_ready;

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      out_n       = out;
      out_valid_n = out_valid;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            if (en && (fill != '0)) begin
               pop                = 1'b1;
               state_n            = DRIVE;
               cnt_n              = '0;
               out_n              = '0;
               out_n[mem[rptr]]   = 1'b1;
               out_valid_n        = 1'b1;
            end
         end
         DRIVE: begin
            if (!en) begin
               state_n     = IDLE;
               out_n       = '0;
               out_valid_n = 1'b0;
            end else if (cnt == 16'(HOLD - 1)) begin
               state_n     = (GAP != 0) ? GAP_ST : IDLE;
               cnt_n       = '0;
               out_n       = '0;
               out_valid_n = 1'b0;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         GAP_ST: begin
            if (!en || (cnt == 16'(GAP - 1))) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         default: begin
            state_n     = IDLE;
            cnt_n       = '0;
            out_n       = '0;
            out_valid_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         fill      <= '0;
         wptr      <= '0;
         rptr      <= '0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         out       <= out_n;
         out_valid <= out_valid_n;
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   fill <= fill + FW'(1);
            2'b01:   fill <= fill - FW'(1);
            default: fill <= fill;
         endcase
         if (in_valid && !in_ready) overflow <= 1'b1;
      end
   end

   // Queue storage carries no reset; entries are only read once written.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= in_code;
   end

endmodule

// File: tb/tb_decoder38_pulse.sv
module tb_decoder38_pulse;

   logic       clk = 1'b0;
   logic       rst, en, in_valid;
   logic [2:0] in_code;
   logic       in_ready;
   logic [7:0] out;
   logic       out_valid;
   logic [2:0] fill;
   logic       overflow;

   int n_checks = 0;
   int n_fail   = 0;

   decoder38_pulse #(.DEPTH(4), .HOLD(2), .GAP(1)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_code(in_code),
      .in_ready(in_ready), .out(out), .out_valid(out_valid), .fill(fill),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_code = '0;
      tick(); tick();
      rst = 1'b0;
      n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h expected 00", out); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (fill !== 3'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_single();
      en = 1'b1; in_valid = 1'b1; in_code = 3'd5;
      tick();                      // edge 0: push
      in_valid = 1'b0;
      n_checks++; if (out !== 8'h00 || fill !== 3'd1) begin n_fail++; $display("FAIL single_e0: got out=%h fill=%0d expected out=00 fill=1", out, fill); end
      tick();                      // edge 1
      n_checks++; if (out !== 8'h20 || out_valid !== 1'b1 || fill !== 3'd0) begin n_fail++; $display("FAIL single_e1: got out=%h v=%b fill=%0d expected out=20 v=1 fill=0", out, out_valid, fill); end
      tick();                      // edge 2
      n_checks++; if (out !== 8'h20 || out_valid !== 1'b1) begin n_fail++; $display("FAIL single_e2: got out=%h v=%b expected out=20 v=1", out, out_valid); end
      tick();                      // edge 3
      n_checks++; if (out !== 8'h00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_e3: got out=%h v=%b expected out=00 v=0", out, out_valid); end
      tick();                      // edge 4
      n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL single_e4: got out=%h expected 00", out); end
   endtask

   task automatic test_burst();
      int         idx = 0;
      int         np = 0;
      int         cyc = 0;
      int         full_seen = 0;
      int         starts[7];
      logic [7:0] vals[7];
      logic       prev_v = 1'b0;
      logic       acc;
      logic [7:0] exp_v;
      en = 1'b1;
      while ((idx < 7 || np < 7) && cyc < 80) begin
         if (idx < 7) begin in_valid = 1'b1; in_code = 3'(idx); end
         else in_valid = 1'b0;
         acc = in_ready && (idx < 7);
         if (fill == 3'd4) full_seen++;
         n_checks++; if (in_ready !== (fill != 3'd4)) begin n_fail++; $display("FAIL burst_in_ready: got %b with fill=%0d", in_ready, fill); end
         tick(); cyc++;
         if (acc) idx++;
         if (out_valid && !prev_v && np < 7) begin starts[np] = cyc; vals[np] = out; np++; end
         prev_v = out_valid;
      end
      in_valid = 1'b0;
      n_checks++; if (np !== 7) begin n_fail++; $display("FAIL burst_count: got %0d pulses expected 7", np); end
      n_checks++; if (full_seen == 0) begin n_fail++; $display("FAIL burst_full: got fill never 4 expected fill=4 reached"); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL burst_overflow: got %b expected 1", overflow); end
      for (int i = 0; i < np; i++) begin
         exp_v = 8'h01 << i;
         n_checks++; if (vals[i] !== exp_v) begin n_fail++; $display("FAIL burst_val%0d: got %h expected %h", i, vals[i], exp_v); end
         if (i > 0) begin
            n_checks++; if (starts[i] - starts[i-1] != 4) begin n_fail++; $display("FAIL burst_space%0d: got %0d expected 4", i, starts[i] - starts[i-1]); end
         end
      end
      drain();
   endtask

   task automatic test_abort();
      en = 1'b0;
      in_valid = 1'b1; in_code = 3'd3; tick();
      in_code = 3'd6; tick();
      in_code = 3'd1; tick();
      in_valid = 1'b0;
      n_checks++; if (fill !== 3'd3 || out !== 8'h00) begin n_fail++; $display("FAIL abort_preload: got fill=%0d out=%h expected fill=3 out=00", fill, out); end
      en = 1'b1; tick();
      n_checks++; if (out !== 8'h08 || fill !== 3'd2) begin n_fail++; $display("FAIL abort_first: got out=%h fill=%0d expected out=08 fill=2", out, fill); end
      en = 1'b0; tick();
      n_checks++; if (out !== 8'h00 || out_valid !== 1'b0 || fill !== 3'd2) begin n_fail++; $display("FAIL abort_drop: got out=%h v=%b fill=%0d expected out=00 v=0 fill=2", out, out_valid, fill); end
      tick(); tick();
      n_checks++; if (out !== 8'h00 || fill !== 3'd2) begin n_fail++; $display("FAIL abort_hold: got out=%h fill=%0d expected out=00 fill=2", out, fill); end
      en = 1'b1; tick();
      n_checks++; if (out !== 8'h40 || fill !== 3'd1) begin n_fail++; $display("FAIL abort_resume: got out=%h fill=%0d expected out=40 fill=1", out, fill); end
      repeat (4) tick();
      n_checks++; if (out !== 8'h02 || fill !== 3'd0) begin n_fail++; $display("FAIL abort_next: got out=%h fill=%0d expected out=02 fill=0", out, fill); end
      drain();
   endtask

   task automatic test_reset_mid();
      en = 1'b0;
      in_valid = 1'b1;
      in_code = 3'd2; tick();
      in_code = 3'd4; tick();
      in_code = 3'd7; tick();
      in_code = 3'd1; tick();
      n_checks++; if (fill !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full: got fill=%0d rdy=%b expected fill=4 rdy=0", fill, in_ready); end
      in_code = 3'd5; tick();
      in_valid = 1'b0;
      n_checks++; if (overflow !== 1'b1 || fill !== 3'd4) begin n_fail++; $display("FAIL rmid_refuse: got ovf=%b fill=%0d expected ovf=1 fill=4", overflow, fill); end
      en = 1'b1; tick();
      n_checks++; if (out !== 8'h04 || fill !== 3'd3) begin n_fail++; $display("FAIL rmid_drive: got out=%h fill=%0d expected out=04 fill=3", out, fill); end
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++; if (out !== 8'h00 || out_valid !== 1'b0 || fill !== 3'd0 || overflow !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_reset: got out=%h v=%b fill=%0d ovf=%b rdy=%b expected 00 0 0 0 1", out, out_valid, fill, overflow, in_ready); end
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++; if (out !== 8'h00 || fill !== 3'd0) begin n_fail++; $display("FAIL rmid_quiet%0d: got out=%h fill=%0d expected out=00 fill=0", i, out, fill); end
      end
   endtask

   task automatic test_extremes();
      logic [7:0] exp_v;
      en = 1'b1;
      in_valid = 1'b1; in_code = 3'd7; tick();
      in_code = 3'd0; tick();
      in_valid = 1'b0;
      n_checks++; if (out !== 8'h80) begin n_fail++; $display("FAIL ext_seven: got %h expected 80", out); end
      tick(); tick();
      n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL ext_gap: got %h expected 00", out); end
      tick(); tick();
      n_checks++; if (out !== 8'h01 || out_valid !== 1'b1) begin n_fail++; $display("FAIL ext_zero: got out=%h v=%b expected out=01 v=1", out, out_valid); end
      drain();
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1; in_code = 3'(k); tick();
         in_valid = 1'b0; tick();
         exp_v = 8'h01 << k;
         n_checks++; if (out !== exp_v || out_valid !== 1'b1) begin n_fail++; $display("FAIL sweep%0d: got out=%h v=%b expected out=%h v=1", k, out, out_valid, exp_v); end
         repeat (3) tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_abort();
      test_reset_mid();
      test_extremes();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
